// File: rtl/alu_filter_coef_loader_if.sv
// Coefficient write/commit bus between the control block and the loader.
// master = register block, slave = alu_filter_coef_loader.
interface alu_filter_coef_loader_if #(
  parameter int COEF_W = 18
);
  logic                     coef_wr_en;
  logic [2:0]               coef_wr_addr;
  logic signed [COEF_W-1:0] coef_wr_data;
  logic                     coef_commit;
  logic                     coef_wr_err;
  logic                     commit_pending;
  logic                     commit_done;

  modport master (
    output coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit,
    input  coef_wr_err, commit_pending, commit_done
  );

  modport slave (
    input  coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit,
    output coef_wr_err, commit_pending, commit_done
  );
endinterface

// File: rtl/alu_filter_coef_loader.sv
// Shadow/active coefficient bank for alu_filter; commits only between samples.
// Optional readback port enabled by ALU_FILTER_COEF_READBACK_EN.
module alu_filter_coef_loader #(
  parameter int NUM_COEFS = 5,
  parameter int COEF_W    = 18
) (
  input  logic                        clk,
  input  logic                        reset_n,
  alu_filter_coef_loader_if.slave     bus,
  input  logic                        filter_sample_in_rdy,
  input  logic                        filter_sample_out_rdy,
`ifdef ALU_FILTER_COEF_READBACK_EN
  input  logic [2:0]                  coef_rd_addr,
  input  logic                        coef_rd_sel,
  output logic [COEF_W-1:0]           coef_rd_data,
`endif
  output logic [NUM_COEFS*COEF_W-1:0] coefs_flat
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_DONE
  } state_e;

  localparam logic [3:0] NUM_L = 4'(NUM_COEFS);

  state_e                      st_q;
  logic [NUM_COEFS*COEF_W-1:0] sh_q;
  logic [NUM_COEFS*COEF_W-1:0] act_q;
  logic                        busy_q;
  logic                        err_q;
  logic                        pend_q;
  logic                        done_q;

  logic addr_ok;
  logic wr_ok;
  logic filter_idle;

  assign addr_ok     = {1'b0, bus.coef_wr_addr} < NUM_L;
  assign wr_ok       = bus.coef_wr_en && addr_ok && (st_q == ST_IDLE);
  // A strobe in this very cycle means a sample is starting now.
  assign filter_idle = !busy_q && !filter_sample_in_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= ST_IDLE;
      sh_q   <= '0;
      act_q  <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (filter_sample_in_rdy)
        busy_q <= 1'b1;
      else if (filter_sample_out_rdy)
        busy_q <= 1'b0;
      err_q  <= bus.coef_wr_en && !wr_ok;
      done_q <= 1'b0;
      if (wr_ok) begin
        for (int i = 0; i < NUM_COEFS; i++)
          if (bus.coef_wr_addr == 3'(i))
            sh_q[i*COEF_W +: COEF_W] <= bus.coef_wr_data;
      end
      unique case (st_q)
        ST_IDLE: begin
          if (bus.coef_commit) begin
            st_q   <= ST_PENDING;
            pend_q <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (filter_idle) begin
            act_q  <= sh_q;
            st_q   <= ST_DONE;
            pend_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          st_q <= ST_IDLE;
        end
        default: begin
          st_q   <= ST_IDLE;
          pend_q <= 1'b0;
        end
      endcase
    end
  end

  assign coefs_flat         = act_q;
  assign bus.coef_wr_err    = err_q;
  assign bus.commit_pending = pend_q;
  assign bus.commit_done    = done_q;

`ifdef ALU_FILTER_COEF_READBACK_EN
  logic [COEF_W-1:0] rd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= '0;
      for (int i = 0; i < NUM_COEFS; i++)
        if (coef_rd_addr == 3'(i))
          rd_q <= coef_rd_sel ? act_q[i*COEF_W +: COEF_W]
                              : sh_q[i*COEF_W +: COEF_W];
    end
  end

  assign coef_rd_data = rd_q;
`endif

endmodule

// File: tb/tb_alu_filter_coef_loader.sv
// Directed bench for alu_filter_coef_loader.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_alu_filter_coef_loader;

  localparam int N = 5;
  localparam int W = 18;

  logic clk = 1'b0;
  logic reset_n;
  logic in_rdy;
  logic out_rdy;
  logic [N*W-1:0] coefs_flat;
  logic [N*W-1:0] exp_flat;
`ifdef ALU_FILTER_COEF_READBACK_EN
  logic [2:0]   rd_addr;
  logic         rd_sel;
  logic [W-1:0] rd_data;
`endif

  int passed = 0;
  int total  = 0;

  alu_filter_coef_loader_if #(.COEF_W(W)) bus ();

  alu_filter_coef_loader #(.NUM_COEFS(N), .COEF_W(W)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .bus                   (bus.slave),
    .filter_sample_in_rdy  (in_rdy),
    .filter_sample_out_rdy (out_rdy),
`ifdef ALU_FILTER_COEF_READBACK_EN
    .coef_rd_addr          (rd_addr),
    .coef_rd_sel           (rd_sel),
    .coef_rd_data          (rd_data),
`endif
    .coefs_flat            (coefs_flat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N*W-1:0] obs,
                     input logic [N*W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = a;
    bus.coef_wr_data = d;
    tick();
    bus.coef_wr_en   = 1'b0;
  endtask

  initial begin
`ifdef ALU_FILTER_COEF_READBACK_EN
    rd_addr = '0;
    rd_sel  = 1'b0;
`endif
    reset_n          = 1'b0;
    in_rdy           = 1'b1;
    out_rdy          = 1'b0;
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = 3'd0;
    bus.coef_wr_data = 18'h2AAAA;
    bus.coef_commit  = 1'b1;
    tick();
    tick();
    chk("rst_flat", coefs_flat, '0);
    chk("rst_pend", 90'(bus.commit_pending), '0);
    chk("rst_done", 90'(bus.commit_done), '0);
    chk("rst_err",  90'(bus.coef_wr_err), '0);
    bus.coef_wr_en  = 1'b0;
    bus.coef_commit = 1'b0;
    in_rdy          = 1'b0;
    reset_n         = 1'b1;
    tick();

    // basic load
    wr(3'd0, 18'h10000);
    wr(3'd1, 18'h0);
    wr(3'd2, 18'h0);
    wr(3'd3, 18'h0);
    wr(3'd4, 18'h0);
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    chk("ld_pend",  90'(bus.commit_pending), 90'd1);
    chk("ld_early", coefs_flat, '0);
    tick();
    exp_flat = '0;
    exp_flat[17:0] = 18'h10000;
    chk("ld_done", 90'(bus.commit_done), 90'd1);
    chk("ld_flat", coefs_flat, exp_flat);
    chk("ld_pend0", 90'(bus.commit_pending), '0);
    tick();
    chk("ld_done0", 90'(bus.commit_done), '0);

    // busy defer
    wr(3'd1, 18'h00123);
    in_rdy = 1'b1;
    tick();
    in_rdy = 1'b0;
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    chk("bz_pend", 90'(bus.commit_pending), 90'd1);
    tick();
    tick();
    tick();
    chk("bz_hold", 90'(bus.commit_pending), 90'd1);
    chk("bz_flat", coefs_flat, exp_flat);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    chk("bz_clr_pend", 90'(bus.commit_pending), 90'd1);
    chk("bz_clr_flat", coefs_flat, exp_flat);
    tick();
    exp_flat[35:18] = 18'h00123;
    chk("bz_done", 90'(bus.commit_done), 90'd1);
    chk("bz_new",  coefs_flat, exp_flat);
    tick();

    // errors
    wr(3'd5, 18'h3FFFF);
    chk("er_addr", 90'(bus.coef_wr_err), 90'd1);
    tick();
    chk("er_addr0", 90'(bus.coef_wr_err), '0);
    in_rdy = 1'b1;
    tick();
    in_rdy = 1'b0;
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    wr(3'd1, 18'h2AAAA);
    chk("er_pend", 90'(bus.coef_wr_err), 90'd1);
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    chk("er_recommit", 90'(bus.coef_wr_err), '0);
    chk("er_stillpend", 90'(bus.commit_pending), 90'd1);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    tick();
    chk("er_done", 90'(bus.commit_done), 90'd1);
    chk("er_flat", coefs_flat, exp_flat);
    tick();
    chk("er_idle", 90'(bus.commit_pending), '0);

    // same-cycle write and commit
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = 3'd2;
    bus.coef_wr_data = 18'h3FFFF;
    bus.coef_commit  = 1'b1;
    tick();
    bus.coef_wr_en  = 1'b0;
    bus.coef_commit = 1'b0;
    chk("wc_err", 90'(bus.coef_wr_err), '0);
    tick();
    exp_flat[53:36] = 18'h3FFFF;
    chk("wc_done", 90'(bus.commit_done), 90'd1);
    chk("wc_flat", coefs_flat, exp_flat);
    tick();

    // reset during pending
    in_rdy = 1'b1;
    tick();
    in_rdy = 1'b0;
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    chk("ab_pend", 90'(bus.commit_pending), 90'd1);
    reset_n = 1'b0;
    #1;
    chk("ab_rst_pend", 90'(bus.commit_pending), '0);
    chk("ab_rst_flat", coefs_flat, '0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("ab_done", 90'(bus.commit_done), '0);
    tick();
    chk("ab_done2", 90'(bus.commit_done), '0);
    chk("ab_flat", coefs_flat, '0);

    // unchanged (zero) shadow still handshakes
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    tick();
    chk("uc_done", 90'(bus.commit_done), 90'd1);
    chk("uc_flat", coefs_flat, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
